// File: rtl/temp_pkg.sv
// Shared definitions for the temperature encoder and the monitor that consumes its
// sign + 3-digit BCD output bundle.
package temp_pkg;

    localparam int BCD_W   = 4;
    localparam int MAX_MAG = 999;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    typedef struct packed {
        logic             sign;
        logic [BCD_W-1:0] huns;
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } temp_bcd_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: any digit of 5 or more gets +3 before the next shift.
module bcd_add3
    import temp_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/temp_bcd_encoder.sv
// Converts a signed binary temperature to sign + clamped 3-digit BCD magnitude,
// one shift-add-3 iteration per cycle, and strobes en when the new digits are loaded.
module temp_bcd_encoder
    import temp_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             sample_ready,
    output logic             en,
    output logic [3:0]       temp_value_ones,
    output logic [3:0]       temp_value_tens,
    output logic [3:0]       temp_value_huns,
    output logic             temp_value_sign,
    output logic             sat
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_BITS = 3 * BCD_W;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     mag_q;
    logic [BCD_BITS-1:0]  bcd_q;
    logic                 sign_q;
    logic                 sat_q;
    temp_bcd_t            out_q;
    logic                 sat_out_q;
    logic                 en_q;

    // |sample| fits WIDTH unsigned bits, so the most negative input stays exact.
    logic [WIDTH-1:0]     mag_abs;
    logic                 over;
    logic [WIDTH-1:0]     mag_in;
    logic                 sign_in;
    logic                 accept;
    logic                 last_iter;
    logic [BCD_BITS-1:0]  bcd_adj;
    logic [BCD_BITS-1:0]  bcd_shift;

    assign mag_abs   = sample[WIDTH-1] ? (~sample) + {{(WIDTH-1){1'b0}}, 1'b1} : sample;
    assign over      = 32'(mag_abs) > MAX_MAG;
    assign mag_in    = over ? WIDTH'(MAX_MAG) : mag_abs;
    assign sign_in   = sample[WIDTH-1] && (sample != '0);
    assign accept    = sample_valid && (state_q == IDLE);
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    bcd_add3 u_add3_ones (.din(bcd_q[BCD_W-1:0]),           .dout(bcd_adj[BCD_W-1:0]));
    bcd_add3 u_add3_tens (.din(bcd_q[2*BCD_W-1:BCD_W]),     .dout(bcd_adj[2*BCD_W-1:BCD_W]));
    bcd_add3 u_add3_huns (.din(bcd_q[3*BCD_W-1:2*BCD_W]),   .dout(bcd_adj[3*BCD_W-1:2*BCD_W]));

    assign bcd_shift = {bcd_adj[BCD_BITS-2:0], mag_q[WIDTH-1]};

    // NOTE: next-state defaults to the current state first so no path leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_valid) state_d = CONV;
            CONV:    if (last_iter)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            mag_q     <= '0;
            bcd_q     <= '0;
            sign_q    <= 1'b0;
            sat_q     <= 1'b0;
            out_q     <= '0;
            sat_out_q <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            en_q <= 1'b0;
            if (accept) begin
                mag_q  <= mag_in;
                sign_q <= sign_in;
                sat_q  <= over;
                bcd_q  <= '0;
                cnt_q  <= '0;
            end else if (state_q == CONV) begin
                bcd_q <= bcd_shift;
                mag_q <= mag_q << 1;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_iter) begin
                    out_q.sign <= sign_q;
                    out_q.huns <= bcd_shift[3*BCD_W-1:2*BCD_W];
                    out_q.tens <= bcd_shift[2*BCD_W-1:BCD_W];
                    out_q.ones <= bcd_shift[BCD_W-1:0];
                    sat_out_q  <= sat_q;
                    en_q       <= 1'b1;
                end
            end
        end
    end

    assign sample_ready    = (state_q == IDLE);
    assign en              = en_q;
    assign temp_value_ones = out_q.ones;
    assign temp_value_tens = out_q.tens;
    assign temp_value_huns = out_q.huns;
    assign temp_value_sign = out_q.sign;
    assign sat             = sat_out_q;

endmodule

// File: tb/tb_temp_bcd_encoder.sv
// Self-checking bench for temp_bcd_encoder: directed cases, back-to-back streams,
// random samples and a full-range sweep against a decimal-arithmetic reference model.
module tb_temp_bcd_encoder;

    localparam int WIDTH = 11;
    localparam int MIN_V = -(1 << (WIDTH - 1));
    localparam int MAX_V = (1 << (WIDTH - 1)) - 1;

    logic             clk;
    logic             rst;
    logic             sample_valid;
    logic [WIDTH-1:0] sample;
    logic             sample_ready;
    logic             en;
    logic [3:0]       temp_value_ones;
    logic [3:0]       temp_value_tens;
    logic [3:0]       temp_value_huns;
    logic             temp_value_sign;
    logic             sat;

    int tests_run = 0;
    int tests_failed = 0;

    temp_bcd_encoder #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_valid    (sample_valid),
        .sample          (sample),
        .sample_ready    (sample_ready),
        .en              (en),
        .temp_value_ones (temp_value_ones),
        .temp_value_tens (temp_value_tens),
        .temp_value_huns (temp_value_huns),
        .temp_value_sign (temp_value_sign),
        .sat             (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: decimal digits of min(|x|, 999) and the sign of x.
    task automatic check_result(input int x);
        int m;
        bit exp_sat;
        m = (x < 0) ? -x : x;
        exp_sat = (m > 999);
        if (exp_sat) m = 999;
        check($sformatf("huns(%0d)", x), int'(temp_value_huns), m / 100);
        check($sformatf("tens(%0d)", x), int'(temp_value_tens), (m / 10) % 10);
        check($sformatf("ones(%0d)", x), int'(temp_value_ones), m % 10);
        check($sformatf("sign(%0d)", x), int'(temp_value_sign), (x < 0) ? 1 : 0);
        check($sformatf("sat(%0d)", x),  int'(sat), exp_sat ? 1 : 0);
    endtask

    // Presents each value until accepted, scrambling sample while not ready when junk=1,
    // and checks gap, latency, strobe shape and results for every en.
    task automatic run_stream(input int vals[$], input bit junk);
        int exp_q[$];
        int acc_q[$];
        int idx = 0;
        int cyc = 0;
        int last_acc = -1;
        int n_acc = 0;
        int n_en = 0;
        bit prev_en = 1'b0;
        int budget;
        budget = vals.size() * (WIDTH + 1) + 50;
        while ((idx < vals.size() || exp_q.size() > 0) && cyc < budget) begin
            @(negedge clk);
            if (idx < vals.size()) begin
                sample_valid = 1'b1;
                if (sample_ready) begin
                    sample = WIDTH'(vals[idx]);
                    if (last_acc >= 0) check("accept_gap", cyc + 1 - last_acc, WIDTH + 1);
                    last_acc = cyc + 1;
                    exp_q.push_back(vals[idx]);
                    acc_q.push_back(cyc + 1);
                    idx++;
                    n_acc++;
                end else if (junk) begin
                    sample = WIDTH'($urandom);
                end
            end else begin
                sample_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (en) begin
                n_en++;
                check("en_back_to_back", int'(prev_en), 0);
                if (exp_q.size() == 0) begin
                    check("spurious_en", n_en, n_acc);
                end else begin
                    check("latency", cyc - acc_q.pop_front(), WIDTH);
                    check_result(exp_q.pop_front());
                end
            end
            prev_en = en;
        end
        sample_valid = 1'b0;
        check("stream_unfinished", (vals.size() - idx) + exp_q.size(), 0);
        check("en_count", n_en, n_acc);
    endtask

    initial begin
        int q[$];
        int en_seen;

        rst = 1'b0;
        sample_valid = 1'b0;
        sample = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_en", int'(en), 0);
        check("reset_digits", int'({temp_value_huns, temp_value_tens, temp_value_ones}), 0);
        check("reset_sign", int'(temp_value_sign), 0);
        check("reset_sat", int'(sat), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_reset", int'(sample_ready), 1);

        // Load non-zero outputs, then abandon a conversion with reset.
        q = '{-1024};
        run_stream(q, 1'b0);
        @(negedge clk);
        sample = WIDTH'(123);
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        check("busy_after_accept", int'(sample_ready), 0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midconv_rst_digits", int'({temp_value_huns, temp_value_tens, temp_value_ones}), 0);
        check("midconv_rst_sign", int'(temp_value_sign), 0);
        check("midconv_rst_sat", int'(sat), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midconv_ready", int'(sample_ready), 1);
        en_seen = 0;
        repeat (WIDTH + 4) begin
            @(posedge clk);
            #1;
            if (en) en_seen++;
        end
        check("midconv_no_en", en_seen, 0);

        q = '{123};
        run_stream(q, 1'b0);
        q = '{-47, 0, -1};
        run_stream(q, 1'b0);
        q = '{1023, -1024, 5};
        run_stream(q, 1'b0);
        q = '{10, 20, 30};
        run_stream(q, 1'b1);

        q.delete();
        for (int i = 0; i < 100; i++) q.push_back(int'($urandom_range(0, 2047)) - 1024);
        run_stream(q, 1'b1);

        q.delete();
        for (int v = MIN_V; v <= MAX_V; v++) q.push_back(v);
        run_stream(q, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
